// File: rtl/tx_port_arb_pkg.sv
// Shared encodings for the two-source packet-atomic TX arbiter.
package tx_port_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } arb_state_t;

   localparam logic [7:0] CTRL_BASE = 8'd128;

   localparam int CTRL_EN0    = 0;
   localparam int CTRL_EN1    = 1;
   localparam int CTRL_FIXPRI = 2;
   localparam int CTRL_CLR    = 3;

   localparam int FLAG_SOP = 0;
   localparam int FLAG_EOP = 1;

   localparam int STALL_W = 10;

endpackage

// File: rtl/tx_port_arb_if.sv
// Ready/flags stream handshake between the two packet sources, the arbiter and TX control.
interface tx_port_arb_if;

   logic [31:0] s0_dat_i;
   logic [3:0]  s0_flags_i;
   logic        s0_ready_i;
   logic        s0_ready_o;

   logic [31:0] s1_dat_i;
   logic [3:0]  s1_flags_i;
   logic        s1_ready_i;
   logic        s1_ready_o;

   logic [31:0] tx_dat_o;
   logic [3:0]  tx_flags_o;
   logic        tx_ready_o;
   logic        tx_ready_i;

   modport slave (
      input  s0_dat_i, s0_flags_i, s0_ready_i,
      input  s1_dat_i, s1_flags_i, s1_ready_i,
      input  tx_ready_i,
      output s0_ready_o, s1_ready_o,
      output tx_dat_o, tx_flags_o, tx_ready_o
   );

   modport master (
      output s0_dat_i, s0_flags_i, s0_ready_i,
      output s1_dat_i, s1_flags_i, s1_ready_i,
      output tx_ready_i,
      input  s0_ready_o, s1_ready_o,
      input  tx_dat_o, tx_flags_o, tx_ready_o
   );

endinterface

// File: rtl/tx_port_arb.sv
// Packet-atomic round-robin / fixed-priority arbiter sharing the TX buffer-pool read stream.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | no packet in flight, arbitrate between requests
// ST_GRANT0 | src0 owns the stream until its eop transfer
// ST_GRANT1 | src1 owns the stream until its eop transfer
module tx_port_arb
   import tx_port_arb_pkg::*;
#(
   parameter logic [7:0] BASE      = CTRL_BASE,
   parameter int         STALL_MAX = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_stb,
   input  logic [7:0]    set_addr,
   input  logic [31:0]   set_data,
   tx_port_arb_if.slave  bus,
   output logic [1:0]    grant,
   output logic [15:0]   pkt_cnt0,
   output logic [15:0]   pkt_cnt1,
   output logic          stall,
   output logic [31:0]   debug
);

   localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

   arb_state_t         state, state_nxt;
   logic               en0, en1, fixpri, last_served;
   logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
   logic               ctrl_wr, clr, req0, req1;
   logic               src_rdy, src_eop, xfer, eop_xfer;
   logic [27:0]        set_data_unused;

   assign ctrl_wr         = set_stb && (set_addr == BASE);
   assign clr             = ctrl_wr && set_data[CTRL_CLR];
   assign set_data_unused = set_data[31:4];
   assign req0            = bus.s0_ready_i & en0;
   assign req1            = bus.s1_ready_i & en1;
   assign xfer            = src_rdy & bus.tx_ready_i;
   assign eop_xfer        = xfer & src_eop;
   assign debug           = {24'b0, stall_cnt[5:0], state};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      grant          = 2'b00;
      src_rdy        = 1'b0;
      src_eop        = 1'b0;
      bus.tx_dat_o   = '0;
      bus.tx_flags_o = '0;
      bus.tx_ready_o = 1'b0;
      bus.s0_ready_o = 1'b0;
      bus.s1_ready_o = 1'b0;
      case (state)
         ST_IDLE: begin
            // last_served==1 means src1 went last, so src0 takes a tie
            if (req0 && req1)
               state_nxt = (fixpri || last_served) ? ST_GRANT0 : ST_GRANT1;
            else if (req0)
               state_nxt = ST_GRANT0;
            else if (req1)
               state_nxt = ST_GRANT1;
         end
         ST_GRANT0: begin
            grant          = 2'b01;
            src_rdy        = bus.s0_ready_i;
            src_eop        = bus.s0_flags_i[FLAG_EOP];
            bus.tx_dat_o   = bus.s0_dat_i;
            bus.tx_flags_o = bus.s0_flags_i;
            bus.tx_ready_o = bus.s0_ready_i;
            bus.s0_ready_o = bus.tx_ready_i & bus.s0_ready_i;
         end
         ST_GRANT1: begin
            grant          = 2'b10;
            src_rdy        = bus.s1_ready_i;
            src_eop        = bus.s1_flags_i[FLAG_EOP];
            bus.tx_dat_o   = bus.s1_dat_i;
            bus.tx_flags_o = bus.s1_flags_i;
            bus.tx_ready_o = bus.s1_ready_i;
            bus.s1_ready_o = bus.tx_ready_i & bus.s1_ready_i;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state != ST_IDLE && bus.tx_ready_i && src_rdy && src_eop)
         state_nxt = ST_IDLE;
   end

   always_comb begin
      stall_cnt_nxt = stall_cnt;
      if (state_nxt == ST_IDLE || xfer)
         stall_cnt_nxt = '0;
      else if (state != ST_IDLE && !src_rdy && stall_cnt != STALL_LIM)
         stall_cnt_nxt = stall_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en0         <= 1'b1;
         en1         <= 1'b1;
         fixpri      <= 1'b0;
         last_served <= 1'b1;
         stall_cnt   <= '0;
         stall       <= 1'b0;
         pkt_cnt0    <= '0;
         pkt_cnt1    <= '0;
      end else begin
         stall_cnt <= stall_cnt_nxt;
         if (ctrl_wr) begin
            en0    <= set_data[CTRL_EN0];
            en1    <= set_data[CTRL_EN1];
            fixpri <= set_data[CTRL_FIXPRI];
         end
         if (eop_xfer)
            last_served <= (state == ST_GRANT1);
         // a clear landing on the same edge as an eop transfer leaves the counter at 0
         if (clr) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            stall    <= 1'b0;
         end else begin
            if (eop_xfer && state == ST_GRANT0) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (eop_xfer && state == ST_GRANT1) pkt_cnt1 <= pkt_cnt1 + 16'd1;
            if (state != ST_IDLE && stall_cnt_nxt == STALL_LIM) stall <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_port_arb.sv
// Directed bench for tx_port_arb: arbitration modes, backpressure, watchdog, clear and reset.
module tb_tx_port_arb;
   import tx_port_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic [1:0]  grant;
   logic [15:0] pkt_cnt0, pkt_cnt1;
   logic        stall;
   logic [31:0] debug;

   tx_port_arb_if bus();

   tx_port_arb #(.BASE(8'd128), .STALL_MAX(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_stb  (set_stb),
      .set_addr (set_addr),
      .set_data (set_data),
      .bus      (bus),
      .grant    (grant),
      .pkt_cnt0 (pkt_cnt0),
      .pkt_cnt1 (pkt_cnt1),
      .stall    (stall),
      .debug    (debug)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   act [2];
   int   len [2];
   int   idx [2];
   int   pkt [2];
   logic hs  [2];
   int   xfers;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word(input int n, input int p, input int i);
      return 32'hA000_0000 + 32'(n << 24) + 32'((p & 255) << 8) + 32'(i & 255);
   endfunction

   task automatic drive_src();
      bus.s0_ready_i = act[0];
      bus.s0_dat_i   = word(0, pkt[0], idx[0]);
      bus.s0_flags_i = {2'b00, idx[0] == len[0] - 1, idx[0] == 0};
      bus.s1_ready_i = act[1];
      bus.s1_dat_i   = word(1, pkt[1], idx[1]);
      bus.s1_flags_i = {2'b00, idx[1] == len[1] - 1, idx[1] == 0};
   endtask

   task automatic pre();
      drive_src();
      #1;
   endtask

   task automatic post();
      hs[0] = bus.s0_ready_o;
      hs[1] = bus.s1_ready_o;
      @(posedge clk);
      #1;
      set_stb = 1'b0;
      for (int n = 0; n < 2; n++) begin
         if (hs[n]) begin
            idx[n]++;
            if (idx[n] == len[n]) begin
               idx[n] = 0;
               pkt[n]++;
            end
         end
      end
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      set_stb  = 1'b1;
      set_addr = 8'd128;
      set_data = v;
   endtask

   initial begin
      for (int n = 0; n < 2; n++) begin
         act[n] = 1'b0; len[n] = 3; idx[n] = 0; pkt[n] = 0;
      end
      bus.tx_ready_i = 1'b1;
      drive_src();
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_txrdy", 32'(bus.tx_ready_o), 32'd0);
      chk("rst_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_debug", debug, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // round robin, both sources offering 3-word packets back to back
      act[0] = 1'b1; act[1] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pre();
         chk("rr_grant", 32'(grant), (i % 4 == 0) ? 32'd0 : (((i / 4) % 2 == 0) ? 32'd1 : 32'd2));
         if (i == 5) chk("rr_debug", debug, 32'h2);
         post();
      end
      act[0] = 1'b0; act[1] = 1'b0;
      pre();
      chk("rr_cnt0", 32'(pkt_cnt0), 32'd2);
      chk("rr_cnt1", 32'(pkt_cnt1), 32'd2);
      post();

      // fixed priority
      wr_ctrl(32'h7); pre(); post();
      act[0] = 1'b1; act[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pre();
         chk("fix_grant", 32'(grant), (i % 4 == 0) ? 32'd0 : 32'd1);
         post();
      end
      act[0] = 1'b0; act[1] = 1'b0;
      pre();
      chk("fix_cnt0", 32'(pkt_cnt0), 32'd5);
      chk("fix_cnt1", 32'(pkt_cnt1), 32'd2);
      post();

      // disabling src1 mid-packet still lets its 5-word packet finish
      wr_ctrl(32'h3); pre(); post();
      act[1] = 1'b1; len[1] = 5;
      for (int i = 0; i < 6; i++) begin
         pre();
         if (i == 0) chk("dis_idle", 32'(grant), 32'd0);
         else begin
            chk("dis_grant", 32'(grant), 32'd2);
            chk("dis_dat", bus.tx_dat_o, word(1, 2, i - 1));
         end
         if (i == 2) wr_ctrl(32'h1);
         post();
      end
      for (int i = 0; i < 3; i++) begin
         pre();
         chk("dis_ignored", 32'(grant), 32'd0);
         chk("dis_s1rdy", 32'(bus.s1_ready_o), 32'd0);
         post();
      end
      act[1] = 1'b0;
      pre();
      chk("dis_cnt1", 32'(pkt_cnt1), 32'd3);
      post();

      // backpressure on a 4-word src0 packet
      wr_ctrl(32'h3); pre(); post();
      act[0] = 1'b1; len[0] = 4; xfers = 0;
      pre();
      chk("bp_idle", 32'(grant), 32'd0);
      post();
      for (int j = 0; j < 7; j++) begin
         bus.tx_ready_i = (j % 2 == 0);
         pre();
         chk("bp_grant", 32'(grant), 32'd1);
         chk("bp_s0rdy", 32'(bus.s0_ready_o), (j % 2 == 0) ? 32'd1 : 32'd0);
         chk("bp_dat", bus.tx_dat_o, word(0, 5, (j + 1) / 2));
         if (bus.tx_ready_o && bus.tx_ready_i) xfers++;
         post();
      end
      act[0] = 1'b0; bus.tx_ready_i = 1'b1;
      pre();
      chk("bp_xfers", 32'(xfers), 32'd4);
      chk("bp_done", 32'(grant), 32'd0);
      chk("bp_cnt0", 32'(pkt_cnt0), 32'd6);
      post();

      // watchdog: sop, then src0 goes quiet for 10 cycles
      len[0] = 3; act[0] = 1'b1;
      pre(); post();
      pre();
      chk("st_sop", 32'(grant), 32'd1);
      post();
      act[0] = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         pre();
         chk("st_grant", 32'(grant), 32'd1);
         chk("st_flag", 32'(stall), (j >= 9) ? 32'd1 : 32'd0);
         chk("st_debug", debug, 32'(((j - 1 > 8) ? 8 : j - 1) << 2) | 32'd1);
         post();
      end
      act[0] = 1'b1;
      pre();
      chk("st_resume", bus.tx_dat_o, word(0, 6, 1));
      post();
      pre(); post();
      act[0] = 1'b0;
      pre();
      chk("st_idle", 32'(grant), 32'd0);
      chk("st_sticky", 32'(stall), 32'd1);
      chk("st_dbg_idle", debug, 32'd0);
      chk("st_cnt0", 32'(pkt_cnt0), 32'd7);
      post();
      wr_ctrl(32'hB); pre(); post();
      pre();
      chk("clr_stall", 32'(stall), 32'd0);
      chk("clr_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("clr_cnt1", 32'(pkt_cnt1), 32'd0);
      post();

      // single-word packet, clear on the same edge as its eop transfer
      len[0] = 1; act[0] = 1'b1;
      pre(); post();
      pre();
      chk("sw_grant", 32'(grant), 32'd1);
      chk("sw_flags", 32'(bus.tx_flags_o), 32'h3);
      wr_ctrl(32'hB);
      post();
      act[0] = 1'b0;
      pre();
      chk("sw_one_cycle", 32'(grant), 32'd0);
      chk("sw_clr_wins", 32'(pkt_cnt0), 32'd0);
      post();
      act[0] = 1'b1;
      pre(); post();
      pre(); post();
      act[0] = 1'b0;
      pre();
      chk("sw_cnt0", 32'(pkt_cnt0), 32'd1);
      post();

      // reset during word 1 of a src1 packet
      act[1] = 1'b1; len[1] = 3;
      pre(); post();
      pre();
      chk("rm_grant", 32'(grant), 32'd2);
      post();
      pre();
      rst = 1'b1;
      #1;
      chk("rm_grant0", 32'(grant), 32'd0);
      chk("rm_txrdy", 32'(bus.tx_ready_o), 32'd0);
      chk("rm_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("rm_cnt1", 32'(pkt_cnt1), 32'd0);
      post();
      idx[1] = 0;
      act[0] = 1'b1; act[1] = 1'b1; len[0] = 3;
      rst = 1'b0;
      pre();
      chk("rm_idle", 32'(grant), 32'd0);
      post();
      pre();
      chk("rm_src0_first", 32'(grant), 32'd1);
      post();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
